// File: rtl/pipe_pkg.sv
// +---------------------------------------------------------------------------+
// | pipe_pkg : shared types and helpers for the pipeline stage registers      |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

package pipe_pkg;

  typedef logic [1:0] pipe_occ_t;

  localparam int unsigned PIPE_MODE_REG  = 0;
  localparam int unsigned PIPE_MODE_SKID = 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic        wb_en;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] alu_res;
    logic [31:0] store_data;
  } ex_mem_t;

  function automatic pipe_occ_t occ_of(input logic main_v, input logic skid_v);
    return pipe_occ_t'({1'b0, main_v}) + pipe_occ_t'({1'b0, skid_v});
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_slot.sv
// +---------------------------------------------------------------------------+
// | pipe_slot : one valid bit plus payload register with load/clear/drop       |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W    = 128,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              drop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Drop only clears the valid bit; stale data is kept until the next load.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clr_i) begin
      valid_d = 1'b0;
      data_d  = RESET_VAL;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (drop_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// +---------------------------------------------------------------------------+
// | pipe_stage_reg : valid/ready pipeline register with flush, stall, skid     |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W    = 128,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int unsigned       SKID      = 1,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              stall,
  output pipe_occ_t         occupancy,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              main_v;
  logic              skid_v;
  logic [DATA_W-1:0] main_data;
  logic              in_fire;
  logic              out_fire;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  assign in_fire  = in_valid & in_ready & ~flush;
  assign out_fire = main_v & out_ready & ~stall;

  generate
    if (SKID == PIPE_MODE_SKID) begin : g_skid
      logic [DATA_W-1:0] skid_data;
      logic [DATA_W-1:0] main_din;
      logic              main_load, main_drop;
      logic              skid_load, skid_drop;

      // When the output drains, main refills from skid first to keep FIFO order.
      assign main_load = out_fire ? (skid_v | in_fire) : (in_fire & ~main_v);
      assign main_din  = (out_fire & skid_v) ? skid_data : in_data;
      assign main_drop = out_fire & ~skid_v & ~in_fire;
      assign skid_load = in_fire & (out_fire ? skid_v : main_v);
      assign skid_drop = out_fire & skid_v & ~in_fire;

      pipe_slot #(.DATA_W(DATA_W), .RESET_VAL(RESET_VAL)) u_main (
        .CLK     (CLK),
        .RST     (RST),
        .clr_i   (flush),
        .load_i  (main_load),
        .drop_i  (main_drop),
        .data_i  (main_din),
        .valid_o (main_v),
        .data_o  (main_data)
      );

      pipe_slot #(.DATA_W(DATA_W), .RESET_VAL(RESET_VAL)) u_skid (
        .CLK     (CLK),
        .RST     (RST),
        .clr_i   (flush),
        .load_i  (skid_load),
        .drop_i  (skid_drop),
        .data_i  (in_data),
        .valid_o (skid_v),
        .data_o  (skid_data)
      );

      assign in_ready = ~RST & ~skid_v;
    end else begin : g_reg
      pipe_slot #(.DATA_W(DATA_W), .RESET_VAL(RESET_VAL)) u_main (
        .CLK     (CLK),
        .RST     (RST),
        .clr_i   (flush),
        .load_i  (in_fire),
        .drop_i  (out_fire & ~in_fire),
        .data_i  (in_data),
        .valid_o (main_v),
        .data_o  (main_data)
      );

      assign skid_v   = 1'b0;
      assign in_ready = ~RST & (~main_v | out_fire);
    end
  endgenerate

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_v & ~out_fire & ~flush & (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid    = main_v;
  assign out_data     = main_data;
  assign occupancy    = occ_of(main_v, skid_v);
  assign stall_cycles = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// +---------------------------------------------------------------------------+
// | tb_pipe_stage_reg : directed bench for skid, register and saturating modes |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_pipe_stage_reg;

  localparam int unsigned DW = 16;
  localparam logic [DW-1:0] RV = 16'h5A5A;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, out_ready, flush, stall;
  logic [DW-1:0] in_data;

  logic          s_in_ready, s_out_valid, r_in_ready, r_out_valid, t_in_ready, t_out_valid;
  logic [DW-1:0] s_out_data, r_out_data, t_out_data;
  logic [1:0]    s_occ, r_occ, t_occ;
  logic [15:0]   s_stall, r_stall;
  logic [1:0]    t_stall;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .RESET_VAL(RV), .SKID(1), .CNT_W(16)) u_skid (
    .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .flush(flush), .stall(stall), .occupancy(s_occ), .stall_cycles(s_stall)
  );

  pipe_stage_reg #(.DATA_W(DW), .RESET_VAL(RV), .SKID(0), .CNT_W(16)) u_reg (
    .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(r_in_ready), .in_data(in_data),
    .out_valid(r_out_valid), .out_ready(out_ready), .out_data(r_out_data),
    .flush(flush), .stall(stall), .occupancy(r_occ), .stall_cycles(r_stall)
  );

  pipe_stage_reg #(.DATA_W(DW), .RESET_VAL(RV), .SKID(1), .CNT_W(2)) u_sat (
    .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(t_in_ready), .in_data(in_data),
    .out_valid(t_out_valid), .out_ready(out_ready), .out_data(t_out_data),
    .flush(flush), .stall(stall), .occupancy(t_occ), .stall_cycles(t_stall)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0; stall = 1'b0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0; stall = 1'b0;
    tick(); tick();
    n_checks++; if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_s_valid: got %0b want 0", s_out_valid); end
    n_checks++; if (s_out_data !== RV) begin n_fail++; $display("FAIL rst_s_data: got %h want %h", s_out_data, RV); end
    n_checks++; if (s_occ !== 2'd0) begin n_fail++; $display("FAIL rst_s_occ: got %0d want 0", s_occ); end
    n_checks++; if (s_stall !== 16'd0) begin n_fail++; $display("FAIL rst_s_stall: got %0d want 0", s_stall); end
    n_checks++; if (s_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_s_ready: got %0b want 0", s_in_ready); end
    n_checks++; if (r_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_r_ready: got %0b want 0", r_in_ready); end
    n_checks++; if (r_out_data !== RV) begin n_fail++; $display("FAIL rst_r_data: got %h want %h", r_out_data, RV); end
    rst = 1'b0;
    #1;
    n_checks++; if (s_in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_s_ready: got %0b want 1", s_in_ready); end
    n_checks++; if (r_in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_r_ready: got %0b want 1", r_in_ready); end
  endtask

  task automatic test_stream;
    apply_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_data = DW'(i);
      tick();
      n_checks++; if (s_out_data !== DW'(i) || s_out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_s_data%0d: got %h/%0b want %h/1", i, s_out_data, s_out_valid, DW'(i)); end
      n_checks++; if (r_out_data !== DW'(i) || r_out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_r_data%0d: got %h/%0b want %h/1", i, r_out_data, r_out_valid, DW'(i)); end
      n_checks++; if (s_occ !== 2'd1 || r_occ !== 2'd1) begin n_fail++; $display("FAIL stream_occ%0d: got %0d/%0d want 1/1", i, s_occ, r_occ); end
    end
    in_valid = 1'b0;
    tick();
    n_checks++; if (s_out_valid !== 1'b0 || r_out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain: got %0b/%0b want 0/0", s_out_valid, r_out_valid); end
    n_checks++; if (s_stall !== 16'd0 || r_stall !== 16'd0) begin n_fail++; $display("FAIL stream_stall: got %0d/%0d want 0/0", s_stall, r_stall); end
  endtask

  task automatic test_backpressure;
    logic [DW-1:0] exp_seq [3];
    exp_seq[0] = 16'h000A; exp_seq[1] = 16'h000B; exp_seq[2] = 16'h000C;
    apply_reset();
    in_valid = 1'b1; in_data = exp_seq[0];
    tick();
    n_checks++; if (s_occ !== 2'd1 || s_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_a: occ %0d rdy %0b want 1/1", s_occ, s_in_ready); end
    in_data = exp_seq[1];
    tick();
    n_checks++; if (s_occ !== 2'd2 || s_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_b: occ %0d rdy %0b want 2/0", s_occ, s_in_ready); end
    in_data = exp_seq[2];
    tick();
    n_checks++; if (s_occ !== 2'd2 || s_out_data !== exp_seq[0]) begin n_fail++; $display("FAIL bp_hold: occ %0d data %h want 2/%h", s_occ, s_out_data, exp_seq[0]); end
    out_ready = 1'b1;
    tick();
    n_checks++; if (s_out_data !== exp_seq[1] || s_occ !== 2'd1 || s_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_out_b: data %h occ %0d rdy %0b want %h/1/1", s_out_data, s_occ, s_in_ready, exp_seq[1]); end
    tick();
    in_valid = 1'b0;
    n_checks++; if (s_out_data !== exp_seq[2] || s_out_valid !== 1'b1 || s_occ !== 2'd1) begin n_fail++; $display("FAIL bp_out_c: data %h v %0b occ %0d want %h/1/1", s_out_data, s_out_valid, s_occ, exp_seq[2]); end
    tick();
    n_checks++; if (s_out_valid !== 1'b0 || s_occ !== 2'd0) begin n_fail++; $display("FAIL bp_empty: v %0b occ %0d want 0/0", s_out_valid, s_occ); end
  endtask

  task automatic test_flush;
    apply_reset();
    in_valid = 1'b1; in_data = 16'h0001;
    tick();
    in_data = 16'h0002;
    tick();
    n_checks++; if (s_occ !== 2'd2) begin n_fail++; $display("FAIL flush_fill: occ %0d want 2", s_occ); end
    flush = 1'b1; in_data = 16'h000D;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (s_out_valid !== 1'b0 || s_occ !== 2'd0 || s_out_data !== RV) begin n_fail++; $display("FAIL flush_s: v %0b occ %0d data %h want 0/0/%h", s_out_valid, s_occ, s_out_data, RV); end
    n_checks++; if (r_out_valid !== 1'b0 || r_out_data !== RV) begin n_fail++; $display("FAIL flush_r: v %0b data %h want 0/%h", r_out_valid, r_out_data, RV); end
    n_checks++; if (s_stall !== 16'd1 || r_stall !== 16'd1) begin n_fail++; $display("FAIL flush_stall: got %0d/%0d want 1/1", s_stall, r_stall); end
    out_ready = 1'b1;
    tick(); tick();
    n_checks++; if (s_out_valid !== 1'b0 || s_out_data === 16'h000D) begin n_fail++; $display("FAIL flush_drop: v %0b data %h want 0/not 000d", s_out_valid, s_out_data); end
  endtask

  task automatic test_stall;
    apply_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h0077;
    tick();
    stall = 1'b1; in_data = 16'h0088;
    tick();
    in_valid = 1'b0;
    n_checks++; if (s_occ !== 2'd2) begin n_fail++; $display("FAIL stall_fill: occ %0d want 2", s_occ); end
    repeat (4) tick();
    n_checks++; if (s_out_data !== 16'h0077 || s_out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold: data %h v %0b want 0077/1", s_out_data, s_out_valid); end
    n_checks++; if (s_stall !== 16'd5) begin n_fail++; $display("FAIL stall_count: got %0d want 5", s_stall); end
    n_checks++; if (t_stall !== 2'd3) begin n_fail++; $display("FAIL stall_sat: got %0d want 3", t_stall); end
    stall = 1'b0;
    tick();
    n_checks++; if (s_out_data !== 16'h0088 || s_occ !== 2'd1) begin n_fail++; $display("FAIL stall_release: data %h occ %0d want 0088/1", s_out_data, s_occ); end
    tick();
    n_checks++; if (s_out_valid !== 1'b0 || s_stall !== 16'd5) begin n_fail++; $display("FAIL stall_after: v %0b cnt %0d want 0/5", s_out_valid, s_stall); end
  endtask

  task automatic test_async_reset;
    apply_reset();
    in_valid = 1'b1; in_data = 16'h0001;
    tick();
    in_data = 16'h0002;
    tick();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (s_out_valid !== 1'b0 || s_occ !== 2'd0 || s_in_ready !== 1'b0) begin n_fail++; $display("FAIL arst_now: v %0b occ %0d rdy %0b want 0/0/0", s_out_valid, s_occ, s_in_ready); end
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if (s_in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_release: rdy %0b want 1", s_in_ready); end
    out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h1234;
    tick();
    in_valid = 1'b0;
    n_checks++; if (s_out_data !== 16'h1234 || s_out_valid !== 1'b1 || s_occ !== 2'd1) begin n_fail++; $display("FAIL arst_first: data %h v %0b occ %0d want 1234/1/1", s_out_data, s_out_valid, s_occ); end
  endtask

  task automatic test_back_to_back;
    apply_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h0011;
    tick();
    in_data = 16'h0022;
    #1;
    n_checks++; if (r_in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %0b want 1", r_in_ready); end
    stall = 1'b1;
    #1;
    n_checks++; if (r_in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_ready: got %0b want 0", r_in_ready); end
    stall = 1'b0;
    tick();
    in_valid = 1'b0;
    n_checks++; if (r_out_data !== 16'h0022 || r_occ !== 2'd1) begin n_fail++; $display("FAIL b2b_load: data %h occ %0d want 0022/1", r_out_data, r_occ); end
    tick();
    n_checks++; if (r_out_valid !== 1'b0 || r_stall !== 16'd0) begin n_fail++; $display("FAIL b2b_drain: v %0b cnt %0d want 0/0", r_out_valid, r_stall); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0; stall = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_stall();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
